clk_reg_bank: RTL and testbench

//  Register bank directly downstream of the SPI slave (spi_block). Consumes its addr/data/write-enable bus,

---
 rtl/clk_reg_pkg.sv | 18 +
 rtl/clk_reg_bank_sticky_status.sv | 41 ++++
 rtl/clk_reg_bank.sv | 143 ++++++++++++++
 tb/tb_clk_reg_bank.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/clk_reg_pkg.sv
// rtl/clk_reg_pkg.sv - shared address map and constants for the clock register bank
package clk_reg_pkg;

    localparam logic [7:0] ADDR_ID       = 8'h00;
    localparam logic [7:0] ADDR_CTRL     = 8'h01;
    localparam logic [7:0] ADDR_DIV_LO   = 8'h02;
    localparam logic [7:0] ADDR_DIV_HI   = 8'h03;
    localparam logic [7:0] ADDR_CMD      = 8'h04;
    localparam logic [7:0] ADDR_STATUS   = 8'h05;
    localparam logic [7:0] ADDR_SCRATCH  = 8'h06;
    localparam logic [7:0] ADDR_WR_COUNT = 8'h07;
    localparam logic [7:0] ADDR_LOCK     = 8'h08;

    localparam logic [7:0] LOCK_KEY   = 8'hA5;
    localparam logic [7:0] ID_DEFAULT = 8'hC3;
    localparam int         STATUS_W   = 8;

endpackage

// File: rtl/clk_reg_bank_sticky_status.sv
// rtl/clk_reg_bank_sticky_status.sv - event edge detectors feeding write-1-to-clear sticky status bits
module sticky_status
    import clk_reg_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [STATUS_W-1:0] i_evt,
    input  logic [STATUS_W-1:0] i_clr,
    output logic [STATUS_W-1:0] o_status
);

    logic [STATUS_W-1:0] r_evt_d;
    logic [STATUS_W-1:0] r_status;
    logic                r_armed;
    logic [STATUS_W-1:0] w_rise;

    // Event history; the arm flag masks the first cycle so a line already high at reset release is not an edge
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_evt_d <= '0;
            r_armed <= 1'b0;
        end else begin
            r_evt_d <= i_evt;
            r_armed <= 1'b1;
        end
    end

    assign w_rise = r_armed ? (i_evt & ~r_evt_d) : '0;

    // Sticky bits: clear first, then OR in new edges so a coincident set wins
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_status <= '0;
        end else begin
            r_status <= (r_status & ~i_clr) | w_rise;
        end
    end

    assign o_status = r_status;

endmodule

// File: rtl/clk_reg_bank.sv
// rtl/clk_reg_bank.sv - register bank behind the SPI slave: clock config, command pulses, sticky status; optional lock via REG_LOCK_EN
module clk_reg_bank
    import clk_reg_pkg::*;
#(
    parameter int          ADDR_W   = 7,
    parameter logic [7:0]  ID_VALUE = ID_DEFAULT,
    parameter logic [15:0] DIV_RST  = 16'd10
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  i_addr_bus,
    input  logic [7:0]  i_data_write_bus,
    input  logic        i_wr_enable_bus,
    output logic [7:0]  o_data_read_bus,
    output logic [7:0]  o_ctrl,
    output logic [15:0] o_divider,
    output logic        o_start,
    output logic        o_sync,
    input  logic [7:0]  i_status_evt
);

    localparam logic [7:0] ADDR_MASK = 8'((9'd1 << ADDR_W) - 9'd1);

    logic        r_wr_en_d;
    logic [7:0]  r_ctrl;
    logic [15:0] r_div_stage;
    logic [15:0] r_divider;
    logic [7:0]  r_scratch;
    logic [7:0]  r_wr_count;
    logic        r_start;
    logic        r_sync;
    logic [7:0]  r_rd_data;

    logic [7:0]  w_addr;
    logic        w_wr_stb;
    logic        w_wr_prot;
    logic        w_unlocked;
    logic        w_lock_bit;
    logic [7:0]  w_status;
    logic [7:0]  w_status_clr;
    logic [7:0]  w_rd_mux;

    assign w_addr = i_addr_bus & ADDR_MASK;

    // Previous write-enable level so a held level produces a single write
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_wr_en_d <= 1'b0;
        else          r_wr_en_d <= i_wr_enable_bus;
    end

    assign w_wr_stb  = i_wr_enable_bus & ~r_wr_en_d;
    assign w_wr_prot = w_wr_stb & w_unlocked;

`ifdef REG_LOCK_EN
    logic r_locked;

    // Lock register: only the key unlocks, any other value locks
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                               r_locked <= 1'b0;
        else if (w_wr_stb && (w_addr == ADDR_LOCK)) r_locked <= (i_data_write_bus != LOCK_KEY);
    end

    assign w_unlocked = ~r_locked;
    assign w_lock_bit = r_locked;
`else
    assign w_unlocked = 1'b1;
    assign w_lock_bit = 1'b0;
`endif

    // Configuration registers; DIV_HI commits the full divider from the new high byte and staged low byte
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ctrl      <= 8'h00;
            r_div_stage <= DIV_RST;
            r_divider   <= DIV_RST;
            r_scratch   <= 8'h00;
        end else begin
            if (w_wr_prot && (w_addr == ADDR_CTRL))   r_ctrl <= i_data_write_bus;
            if (w_wr_prot && (w_addr == ADDR_DIV_LO)) r_div_stage[7:0] <= i_data_write_bus;
            if (w_wr_prot && (w_addr == ADDR_DIV_HI)) begin
                r_div_stage[15:8] <= i_data_write_bus;
                r_divider         <= {i_data_write_bus, r_div_stage[7:0]};
            end
            if (w_wr_stb && (w_addr == ADDR_SCRATCH)) r_scratch <= i_data_write_bus;
        end
    end

    // Command pulses last exactly one cycle because they are recomputed from the strobe every cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_start <= 1'b0;
            r_sync  <= 1'b0;
        end else begin
            r_start <= w_wr_prot && (w_addr == ADDR_CMD) && i_data_write_bus[0];
            r_sync  <= w_wr_prot && (w_addr == ADDR_CMD) && i_data_write_bus[1];
        end
    end

    // Every accepted write strobe counts, whatever the address or lock state
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)      r_wr_count <= 8'h00;
        else if (w_wr_stb) r_wr_count <= r_wr_count + 8'h01;
    end

    assign w_status_clr = (w_wr_stb && (w_addr == ADDR_STATUS)) ? i_data_write_bus : 8'h00;

    sticky_status u_sticky_status (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_evt    (i_status_evt),
        .i_clr    (w_status_clr),
        .o_status (w_status)
    );

    // Read decode of the current register contents
    always_comb begin
        w_rd_mux = 8'h00;
        case (w_addr)
            ADDR_ID:       w_rd_mux = ID_VALUE;
            ADDR_CTRL:     w_rd_mux = r_ctrl;
            ADDR_DIV_LO:   w_rd_mux = r_div_stage[7:0];
            ADDR_DIV_HI:   w_rd_mux = r_div_stage[15:8];
            ADDR_STATUS:   w_rd_mux = w_status;
            ADDR_SCRATCH:  w_rd_mux = r_scratch;
            ADDR_WR_COUNT: w_rd_mux = r_wr_count;
            ADDR_LOCK:     w_rd_mux = {7'b0, w_lock_bit};
            default:       w_rd_mux = 8'h00;
        endcase
    end

    // Registered read data, one cycle behind address or register changes
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_rd_data <= 8'h00;
        else          r_rd_data <= w_rd_mux;
    end

    assign o_data_read_bus = r_rd_data;
    assign o_ctrl          = r_ctrl;
    assign o_divider       = r_divider;
    assign o_start         = r_start;
    assign o_sync          = r_sync;

endmodule

// File: tb/tb_clk_reg_bank.sv
// tb/tb_clk_reg_bank.sv - self-checking bench for clk_reg_bank (lock checks follow REG_LOCK_EN)
module tb_clk_reg_bank;

`ifdef REG_LOCK_EN
    localparam bit LOCK_ON = 1'b1;
`else
    localparam bit LOCK_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  addr;
    logic [7:0]  wdata;
    logic        wr;
    logic [7:0]  evt;
    logic [7:0]  rd;
    logic [7:0]  ctrl;
    logic [15:0] divider;
    logic        start;
    logic        sync_p;

    int n_checks = 0;
    int n_err    = 0;
    int n_wr     = 0;

    always #50 clk = ~clk;

    clk_reg_bank dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_addr_bus       (addr),
        .i_data_write_bus (wdata),
        .i_wr_enable_bus  (wr),
        .o_data_read_bus  (rd),
        .o_ctrl           (ctrl),
        .o_divider        (divider),
        .o_start          (start),
        .o_sync           (sync_p),
        .i_status_evt     (evt)
    );

    // Reference model: named registers updated once per clock from the sampled bus
    logic [7:0]  m_ctrl, m_scratch, m_status, m_count, m_rd;
    logic [15:0] m_stage, m_div;
    logic        m_locked, m_prev_wr, m_armed, m_start, m_sync;
    logic [7:0]  m_prev_evt;
    logic [7:0]  m_a, m_rise, m_next_rd;

    function automatic logic [7:0] model_read(input logic [7:0] a);
        case (a)
            8'h00:   return 8'hC3;
            8'h01:   return m_ctrl;
            8'h02:   return m_stage[7:0];
            8'h03:   return m_stage[15:8];
            8'h05:   return m_status;
            8'h06:   return m_scratch;
            8'h07:   return m_count;
            8'h08:   return LOCK_ON ? {7'b0, m_locked} : 8'h00;
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ctrl = 0; m_scratch = 0; m_status = 0; m_count = 0; m_rd = 0;
            m_stage = 16'd10; m_div = 16'd10;
            m_locked = 0; m_prev_wr = 0; m_armed = 0; m_start = 0; m_sync = 0;
            m_prev_evt = 0;
        end else begin
            m_a       = addr & 8'h7F;
            m_next_rd = model_read(m_a);
            m_rise    = m_armed ? (evt & ~m_prev_evt) : 8'h00;
            m_start   = 0;
            m_sync    = 0;
            if (wr && !m_prev_wr) begin
                m_count = m_count + 8'd1;
                if (!(LOCK_ON && m_locked)) begin
                    case (m_a)
                        8'h01: m_ctrl = wdata;
                        8'h02: m_stage[7:0] = wdata;
                        8'h03: begin m_stage[15:8] = wdata; m_div = m_stage; end
                        8'h04: begin m_start = wdata[0]; m_sync = wdata[1]; end
                        default: ;
                    endcase
                end
                if (m_a == 8'h05) m_status = m_status & ~wdata;
                if (m_a == 8'h06) m_scratch = wdata;
                if (m_a == 8'h08 && LOCK_ON) m_locked = (wdata != 8'hA5);
            end
            m_status   = m_status | m_rise;
            m_prev_evt = evt;
            m_armed    = 1;
            m_prev_wr  = wr;
            m_rd       = m_next_rd;
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("cmp_rd",      {8'h0, rd},       {8'h0, m_rd});
            check("cmp_ctrl",    {8'h0, ctrl},     {8'h0, m_ctrl});
            check("cmp_divider", divider,          m_div);
            check("cmp_start",   {15'h0, start},   {15'h0, m_start});
            check("cmp_sync",    {15'h0, sync_p},  {15'h0, m_sync});
        end
    end

    task automatic write(input logic [7:0] a, input logic [7:0] d, input int hold);
        @(posedge clk); #1;
        addr = a; wdata = d; wr = 1'b1;
        repeat (hold) @(posedge clk);
        #1 wr = 1'b0;
        n_wr++;
    endtask

    task automatic read_lit(input string name, input logic [7:0] a, input logic [7:0] exp);
        @(posedge clk); #1 addr = a;
        @(posedge clk); #1;
        check(name, {8'h0, rd}, {8'h0, exp});
    endtask

    initial begin
        rst_n = 1'b0; addr = 0; wdata = 0; wr = 0; evt = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_divider", divider, 16'd10);
        check("rst_ctrl",    {8'h0, ctrl}, 16'h0);
        check("rst_rd",      {8'h0, rd}, 16'h0);
        check("rst_pulses",  {14'h0, start, sync_p}, 16'h0);
        rst_n = 1'b1;

        read_lit("id", 8'h00, 8'hC3);

        write(8'h01, 8'h5A, 20);
        check("ctrl_held", {8'h0, ctrl}, 16'h005A);
        read_lit("wr_count_single", 8'h07, 8'h01);

        write(8'h02, 8'h34, 1);
        check("div_unchanged", divider, 16'd10);
        read_lit("div_lo_rd", 8'h02, 8'h34);
        write(8'h03, 8'h12, 1);
        check("div_commit", divider, 16'h1234);

        write(8'h04, 8'h03, 1);
        check("cmd_high", {14'h0, start, sync_p}, 16'h0003);
        @(posedge clk); #1;
        check("cmd_low", {14'h0, start, sync_p}, 16'h0000);
        read_lit("cmd_rd", 8'h04, 8'h00);

        @(posedge clk); #1 evt = 8'h04;
        @(posedge clk); #1 evt = 8'h00;
        read_lit("status_set", 8'h05, 8'h04);
        @(posedge clk); #1;
        addr = 8'h05; wdata = 8'h04; wr = 1'b1; evt = 8'h04;
        @(posedge clk); #1 wr = 1'b0; evt = 8'h00; n_wr++;
        read_lit("status_set_wins", 8'h05, 8'h04);
        write(8'h05, 8'h04, 1);
        read_lit("status_clr", 8'h05, 8'h00);

        write(8'h06, 8'h99, 1);
        read_lit("scratch", 8'h06, 8'h99);
        write(8'h20, 8'h55, 1);
        read_lit("unmapped", 8'h20, 8'h00);
        read_lit("alias", 8'h81, 8'h5A);

        if (LOCK_ON) begin
            write(8'h08, 8'h00, 1);
            read_lit("lock_rd1", 8'h08, 8'h01);
            write(8'h01, 8'hFF, 1);
            check("ctrl_locked", {8'h0, ctrl}, 16'h005A);
            write(8'h08, 8'hA5, 1);
            read_lit("lock_rd0", 8'h08, 8'h00);
            write(8'h01, 8'hFF, 1);
            check("ctrl_unlocked", {8'h0, ctrl}, 16'h00FF);
        end else begin
            write(8'h08, 8'h00, 1);
            read_lit("no_lock_rd", 8'h08, 8'h00);
            write(8'h01, 8'hFF, 1);
            check("ctrl_nolock", {8'h0, ctrl}, 16'h00FF);
        end

        while (n_wr < 255) write(8'h06, 8'(n_wr), 1);
        read_lit("count_ff", 8'h07, 8'hFF);
        write(8'h09, 8'h00, 1);
        read_lit("count_wrap", 8'h07, 8'h00);

        @(posedge clk); #1;
        addr = 8'h04; wdata = 8'h01; wr = 1'b1;
        @(posedge clk); #1;
        check("pulse_before_rst", {15'h0, start}, 16'h1);
        #10 rst_n = 1'b0; wr = 1'b0; evt = 8'h01;
        #1;
        check("pulse_killed", {15'h0, start}, 16'h0);
        check("rst2_divider", divider, 16'd10);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        read_lit("evt_at_release", 8'h05, 8'h00);
        #1 evt = 8'h00;
        write(8'h03, 8'h77, 1);
        check("div_hi_only", divider, 16'h770A);
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
